// File: rtl/rle_fast_param.sv
// Run-length encoder: reads a byte message through SRAM port A and writes packed
// (symbol,count) pairs back through the same port. COUNT_W=8 packs two pairs per word.
module rle_fast_param #(
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned MAX_RUN = (1 << COUNT_W) - 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] message_addr,
  input  logic [31:0] message_size,
  input  logic [31:0] rle_addr,
  output logic [31:0] rle_size,
  output logic        done,
  output logic        port_A_clk,
  output logic [15:0] port_A_addr,
  output logic        port_A_we,
  output logic [31:0] port_A_data_in,
  input  logic [31:0] port_A_data_out
);

  localparam bit WIDE = (COUNT_W > 8);

  // state | meaning
  // IDLE  | waiting for start; done holds the last result
  // RD    | read address on port A
  // CAP   | capture read word, advance read address
  // SCAN  | consume one byte (or four on the fast path), or emit the final pair
  // WR    | write one full output word
  // FIN   | flush a half-filled word, then raise done
  typedef enum logic [2:0] {IDLE, RD, CAP, SCAN, WR, FIN} state_t;

  state_t             state, resume, after;
  logic [15:0]        read_addr, write_addr, size, total, total_nxt;
  logic [31:0]        byte_str, pair_word, full_word;
  logic [1:0]         idx;
  logic [7:0]         symbol, cur_byte;
  logic [COUNT_W-1:0] count;
  logic               half, fast, same, mid_emit, wr_now;
  logic [15:0]        buf_lo;

  logic unused_bits;
  assign unused_bits = ^{message_addr[31:16], message_size[31:16], rle_addr[31:16]};

  assign port_A_clk = clk;

  always_comb begin
    cur_byte  = byte_str[{idx, 3'b000} +: 8];
    fast      = (idx == 2'd0) && (count != '0) && (byte_str == {4{symbol}})
                && (({1'b0, total} + 17'd4) <= {1'b0, size})
                && ((32'(count) + 32'd4) <= MAX_RUN);
    same      = (cur_byte == symbol) && (32'(count) < MAX_RUN);
    mid_emit  = !fast && (count != '0) && !same;
    total_nxt = total + (fast ? 16'd4 : 16'd1);
    if (total_nxt == size)              after = SCAN;
    else if (fast || idx == 2'd3)       after = RD;
    else                                after = SCAN;
    pair_word = 32'({symbol, count});
    full_word = WIDE ? pair_word : {pair_word[15:0], buf_lo};
    wr_now    = mid_emit && (WIDE || half);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      resume         <= IDLE;
      done           <= 1'b0;
      rle_size       <= '0;
      port_A_we      <= 1'b0;
      port_A_addr    <= '0;
      port_A_data_in <= '0;
      read_addr      <= '0;
      write_addr     <= '0;
      size           <= '0;
      total          <= '0;
      byte_str       <= '0;
      idx            <= '0;
      symbol         <= '0;
      count          <= '0;
      half           <= 1'b0;
      buf_lo         <= '0;
    end else begin
      // port A idles on the read address unless a write is being issued
      port_A_we   <= 1'b0;
      port_A_addr <= read_addr;
      case (state)
        IDLE: if (start) begin
          read_addr   <= message_addr[15:0];
          port_A_addr <= message_addr[15:0];
          write_addr  <= rle_addr[15:0];
          size        <= message_size[15:0];
          rle_size    <= '0;
          done        <= 1'b0;
          count       <= '0;
          total       <= '0;
          half        <= 1'b0;
          buf_lo      <= '0;
          state       <= (message_size[15:0] == 16'd0) ? FIN : RD;
        end
        RD: state <= CAP;
        CAP: begin
          byte_str    <= port_A_data_out;
          read_addr   <= read_addr + 16'd4;
          port_A_addr <= read_addr + 16'd4;
          idx         <= 2'd0;
          state       <= SCAN;
        end
        SCAN: if (total == size) begin
          port_A_we   <= 1'b1;
          port_A_addr <= write_addr;
          half        <= 1'b0;
          if (WIDE || half) begin
            port_A_data_in <= full_word;
            resume         <= FIN;
            state          <= WR;
          end else begin
            port_A_data_in <= {16'h0000, pair_word[15:0]};
            state          <= FIN;
          end
        end else begin
          total <= total_nxt;
          idx   <= idx + 2'd1;
          if (fast) begin
            count <= count + COUNT_W'(4);
          end else if (mid_emit) begin
            symbol <= cur_byte;
            count  <= COUNT_W'(1);
            if (WIDE || half) begin
              port_A_we      <= 1'b1;
              port_A_addr    <= write_addr;
              port_A_data_in <= full_word;
              half           <= 1'b0;
            end else begin
              buf_lo <= pair_word[15:0];
              half   <= 1'b1;
            end
          end else begin
            symbol <= cur_byte;
            count  <= count + COUNT_W'(1);
          end
          resume <= after;
          state  <= wr_now ? WR : after;
        end
        WR: begin
          write_addr <= write_addr + 16'd4;
          rle_size   <= rle_size + 32'd4;
          if (resume == FIN) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= resume;
          end
        end
        FIN: begin
          if (port_A_we) begin
            write_addr <= write_addr + 16'd4;
            rle_size   <= rle_size + 32'd4;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_fast_param.sv
// Bench for rle_fast_param: three encoder configurations on a shared SRAM model,
// directed cases plus randomized messages checked against a run-list reference.
module tb_rle_fast_param;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] message_addr, message_size, rle_addr;
  logic        start [3];
  logic [31:0] rle_size [3];
  logic        done [3];
  logic        pclk_unused [3];
  logic [15:0] paddr [3];
  logic        pwe [3];
  logic [31:0] pdin [3];
  logic [31:0] pdout [3];

  logic [31:0] mem [16384];
  int cyc = 0;
  logic [15:0] wlog_addr [$];
  logic [31:0] wlog_data [$];
  int          wlog_dut [$];
  int          wlog_cyc [$];

  logic [7:0]  msg_q [$];
  logic [31:0] exp_q [$];
  logic [7:0]  pad_byte;
  int checks = 0;
  int errors = 0;
  int last_latency;

  always #5 clk = ~clk;

  rle_fast_param dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .message_addr(message_addr),
    .message_size(message_size), .rle_addr(rle_addr), .rle_size(rle_size[0]),
    .done(done[0]), .port_A_clk(pclk_unused[0]), .port_A_addr(paddr[0]),
    .port_A_we(pwe[0]), .port_A_data_in(pdin[0]), .port_A_data_out(pdout[0]));
  rle_fast_param #(.COUNT_W(24)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .message_addr(message_addr),
    .message_size(message_size), .rle_addr(rle_addr), .rle_size(rle_size[1]),
    .done(done[1]), .port_A_clk(pclk_unused[1]), .port_A_addr(paddr[1]),
    .port_A_we(pwe[1]), .port_A_data_in(pdin[1]), .port_A_data_out(pdout[1]));
  rle_fast_param #(.COUNT_W(8), .MAX_RUN(6)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .message_addr(message_addr),
    .message_size(message_size), .rle_addr(rle_addr), .rle_size(rle_size[2]),
    .done(done[2]), .port_A_clk(pclk_unused[2]), .port_A_addr(paddr[2]),
    .port_A_we(pwe[2]), .port_A_data_in(pdin[2]), .port_A_data_out(pdout[2]));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 3; g++) begin
      pdout[g] <= mem[paddr[g][15:2]];
      if (pwe[g]) begin
        wlog_addr.push_back(paddr[g]);
        wlog_data.push_back(pdin[g]);
        wlog_dut.push_back(g);
        wlog_cyc.push_back(cyc);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: split the message into runs capped at mr, then pack the pairs.
  task automatic build_expected(input int cw, input int mr);
    logic [7:0]  sym;
    int          cnt;
    logic [7:0]  ps [$];
    int          pc [$];
    logic [31:0] c_a, c_b;
    logic [15:0] lo, hi;
    exp_q.delete();
    sym = 8'h00;
    cnt = 0;
    for (int i = 0; i < msg_q.size(); i++) begin
      if (i == 0) begin sym = msg_q[0]; cnt = 1; end
      else if (msg_q[i] == sym && cnt < mr) cnt++;
      else begin ps.push_back(sym); pc.push_back(cnt); sym = msg_q[i]; cnt = 1; end
    end
    if (msg_q.size() > 0) begin ps.push_back(sym); pc.push_back(cnt); end
    if (cw == 24) begin
      for (int k = 0; k < ps.size(); k++) begin
        c_a = pc[k];
        exp_q.push_back({ps[k], c_a[23:0]});
      end
    end else begin
      for (int k = 0; k < ps.size(); k += 2) begin
        c_a = pc[k];
        lo  = {ps[k], c_a[7:0]};
        hi  = 16'h0000;
        if (k + 1 < ps.size()) begin c_b = pc[k+1]; hi = {ps[k+1], c_b[7:0]}; end
        exp_q.push_back({hi, lo});
      end
    end
  endtask

  task automatic prep_case(input logic [15:0] maddr, input logic [15:0] raddr,
                           input int cw, input int mr);
    logic [31:0] word;
    logic [13:0] widx;
    int n;
    n = msg_q.size();
    for (int w = 0; w < (n + 3) / 4; w++) begin
      word = {4{pad_byte}};
      for (int b = 0; b < 4; b++)
        if (w * 4 + b < n) word[8*b +: 8] = msg_q[w*4+b];
      widx = maddr[15:2] + 14'(w);
      mem[widx] = word;
    end
    build_expected(cw, mr);
    message_addr = {16'($urandom), maddr};
    message_size = 32'(n);
    rle_addr     = {16'($urandom), raddr};
  endtask

  task automatic run_case(input int g, input string name, input bit restart);
    int t0, done_cyc, n, nw;
    bit seen;
    n = msg_q.size();
    wlog_addr.delete(); wlog_data.delete(); wlog_dut.delete(); wlog_cyc.delete();
    @(negedge clk);
    start[g] = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start[g] = 1'b0;
    if (n > 0) begin
      check_val({name, " rd_addr"}, 32'(paddr[g]), 32'(message_addr[15:0]));
      check_val({name, " rd_we"}, 32'(pwe[g]), 32'd0);
    end else begin
      check_val({name, " done_early"}, 32'(done[g]), 32'd0);
    end
    seen = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      start[g] = restart && (cyc == t0 + 4);
      if (done[g]) begin seen = 1'b1; done_cyc = cyc; break; end
    end
    start[g] = 1'b0;
    check_val({name, " done_seen"}, 32'(seen), 32'd1);
    if (!seen) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    last_latency = done_cyc - t0;
    nw = wlog_addr.size();
    check_val({name, " n_writes"}, 32'(nw), 32'(exp_q.size()));
    for (int k = 0; k < nw && k < exp_q.size(); k++) begin
      check_val($sformatf("%s w%0d addr", name, k), 32'(wlog_addr[k]),
                32'(16'(rle_addr[15:0] + 16'(4 * k))));
      check_val($sformatf("%s w%0d data", name, k), wlog_data[k], exp_q[k]);
      check_val($sformatf("%s w%0d port", name, k), 32'(wlog_dut[k]), 32'(g));
    end
    check_val({name, " rle_size"}, rle_size[g], 32'(4 * exp_q.size()));
    if (nw > 0)
      check_val({name, " done_after_wr"}, 32'(done_cyc), 32'(wlog_cyc[nw-1] + 1));
    else
      check_val({name, " done_zero"}, 32'(done_cyc), 32'(t0 + 2));
  endtask

  initial begin
    int g, n, len, cw, mr;
    logic [7:0] sym;
    reset = 1'b1;
    message_addr = '0; message_size = '0; rle_addr = '0;
    pad_byte = 8'hFF;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("rst%0d done", i), 32'(done[i]), 32'd0);
      check_val($sformatf("rst%0d size", i), rle_size[i], 32'd0);
      check_val($sformatf("rst%0d we", i), 32'(pwe[i]), 32'd0);
      check_val($sformatf("rst%0d addr", i), 32'(paddr[i]), 32'd0);
      check_val($sformatf("rst%0d din", i), pdin[i], 32'd0);
    end

    msg_q = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h42, 8'h42};
    prep_case(16'h0100, 16'h2000, 8, 255);
    check_val("t1 model", exp_q[0], 32'h42024106);
    run_case(0, "t1", 1'b0);

    msg_q.delete();
    for (int i = 0; i < 300; i++) msg_q.push_back(8'h00);
    prep_case(16'h0200, 16'h2100, 8, 255);
    run_case(0, "zeros300", 1'b0);
    check_val("zeros300 fast", 32'(last_latency < 300), 32'd1);

    msg_q = '{8'h01, 8'h02, 8'h03};
    prep_case(16'h0400, 16'h2200, 8, 255);
    run_case(0, "size3", 1'b0);

    msg_q = '{8'h07, 8'h07, 8'h07, 8'h07};
    prep_case(16'h0500, 16'h2300, 24, 16777215);
    run_case(1, "cw24", 1'b0);

    msg_q.delete();
    prep_case(16'h0600, 16'h2400, 8, 255);
    run_case(0, "zero", 1'b0);

    msg_q = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h42, 8'h42};
    prep_case(16'h0040, 16'h0800, 8, 255);
    wlog_addr.delete(); wlog_data.delete(); wlog_dut.delete(); wlog_cyc.delete();
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check_val("midrst we", 32'(pwe[0]), 32'd0);
    check_val("midrst done", 32'(done[0]), 32'd0);
    check_val("midrst size", rle_size[0], 32'd0);
    check_val("midrst writes", 32'(wlog_addr.size()), 32'd0);
    run_case(0, "t1_again", 1'b0);

    msg_q.delete();
    for (int i = 0; i < 17; i++) msg_q.push_back(8'h5A);
    msg_q.push_back(8'h11); msg_q.push_back(8'h5A);
    prep_case(16'hFFF8, 16'hFFF8, 8, 6);
    run_case(2, "wrap_sat", 1'b1);

    for (int it = 0; it < 40; it++) begin
      g = $urandom_range(0, 2);
      cw = (g == 1) ? 24 : 8;
      mr = (g == 0) ? 255 : (g == 1) ? 16777215 : 6;
      case ($urandom_range(0, 9))
        0:       n = $urandom_range(0, 4);
        8, 9:    n = $urandom_range(60, 200);
        default: n = $urandom_range(1, 40);
      endcase
      msg_q.delete();
      while (msg_q.size() < n) begin
        sym = 8'($urandom_range(0, 3));
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 30) : $urandom_range(1, 4);
        for (int j = 0; j < len && msg_q.size() < n; j++) msg_q.push_back(sym);
      end
      pad_byte = 8'($urandom);
      prep_case({14'($urandom), 2'b00}, {14'($urandom), 2'b00}, cw, mr);
      run_case(g, $sformatf("rnd%0d", it), (n >= 5) && ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
